// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for 16 requesters with a bounded grant tenure.
// The grant is presented both as a 4-bit index and as its one-hot decode,
// so the one-hot vector can drive per-agent select/enable lines directly.
//
// Grant handshake: gnt_valid high means the resource belongs to requester
// gnt_idx for this cycle and gnt == one-hot(gnt_idx). gnt_valid low means
// nobody owns it and gnt is all zero. A grant is held while the owner keeps
// its req bit high and en stays high, for at most MAX_HOLD cycles. Every
// release is followed by exactly one dead cycle before the next grant.
// preempt pulses for one cycle (the dead cycle) when a grant was revoked
// because its tenure ran out rather than being given up.
module rr_decode_arbiter #(
    parameter int N_REQ    = 16,
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [3:0]       gnt_idx,
    output logic             gnt_valid,
    output logic             preempt
);

    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;
    logic [IDX_W-1:0] ptr;

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] cand;
    logic             owner_req;
    logic             hold_expired;

    // One-hot decode of an index, same encoding as the 4-to-16 decoders.
    function automatic logic [N_REQ-1:0] decode(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] onehot;
        onehot      = '0;
        onehot[idx] = 1'b1;
        return onehot;
    endfunction

    // Winner search: first set req bit scanning upward from ptr+1, wrapping
    // 15 -> 0; the index adder wraps naturally at 4 bits.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ptr + IDX_W'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Owner still wants the resource, and whether its tenure is used up.
    always_comb begin
        owner_req    = req[gnt_idx];
        hold_expired = (hold_cnt == CNT_W'(MAX_HOLD));
    end

    // Arbitration FSM; all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
            hold_cnt  <= '0;
            ptr       <= '1;
        end else begin
            preempt <= 1'b0;
            case (state)
                // RELEASE is the dead cycle; its exit check is the IDLE one,
                // using the pointer already moved past the last owner.
                IDLE, RELEASE: begin
                    if (en && win_found) begin
                        state     <= GRANT;
                        gnt_idx   <= win_idx;
                        gnt       <= decode(win_idx);
                        gnt_valid <= 1'b1;
                        hold_cnt  <= CNT_W'(1);
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    if (!en || !owner_req || hold_expired) begin
                        state     <= RELEASE;
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_idx;
                        hold_cnt  <= '0;
                        // Only a timeout counts as a revocation.
                        preempt   <= en && owner_req;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= '0;
                    gnt_valid <= 1'b0;
                    hold_cnt  <= '0;
                end
            endcase
        end
    end

    // The one-hot grant is always the gated decode of the index.
    a_gnt_decode: assert property (@(posedge clk) disable iff (!rst_n)
        gnt == (gnt_valid ? decode(gnt_idx) : '0));

    // A revocation pulse only ever appears while nothing is granted.
    a_preempt_dead: assert property (@(posedge clk) disable iff (!rst_n)
        preempt |-> !gnt_valid);

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Bench for rr_decode_arbiter: directed scenarios followed by randomized
// request traffic, checked cycle by cycle against a reference model of the
// arbitration rules through an expected-value queue.
module tb_rr_decode_arbiter;

    localparam int MAX_HOLD = 8;
    localparam int REC_W    = 22;

    // ---------------- clock / reset ----------------
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b1;
    logic [15:0] req   = 16'hFFFF;

    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_valid;
    logic        preempt;

    always #5 clk = ~clk;

    rr_decode_arbiter #(
        .N_REQ    (16),
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    // ---------------- scoreboard state ----------------
    logic [REC_W-1:0] exp_q[$];
    int  n_cmp    = 0;
    int  n_fail   = 0;
    bit  mon_done = 1'b1;

    // Reference model: who owns the resource, for how long, who owned last.
    int  m_owner  = -1;
    int  m_tenure = 0;
    int  m_last   = 15;
    int  m_idx    = 0;
    bit  m_pre    = 1'b0;

    function automatic logic [REC_W-1:0] make_rec(input int owner, input int shown, input bit pre);
        logic [15:0] g;
        logic [3:0]  i;
        g = '0;
        if (owner >= 0) g[owner] = 1'b1;
        i = 4'(shown);
        return {g, i, (owner >= 0), pre};
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_tenure = 0;
        m_last   = 15;
        m_idx    = 0;
        m_pre    = 1'b0;
    endtask

    // One clock edge of the arbitration rules with the sampled inputs.
    task automatic model_step(input bit e, input logic [15:0] r);
        bit found;
        int cand;
        m_pre = 1'b0;
        if (m_owner >= 0) begin
            if (!e || !r[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end else if (m_tenure == MAX_HOLD) begin
                m_last  = m_owner;
                m_owner = -1;
                m_pre   = 1'b1;
            end else begin
                m_tenure++;
            end
        end else if (e && r != 16'h0000) begin
            found = 1'b0;
            for (int k = 1; k <= 16; k++) begin
                cand = (m_last + k) % 16;
                if (!found && r[cand]) begin
                    found   = 1'b1;
                    m_owner = cand;
                end
            end
            m_tenure = 1;
            m_idx    = m_owner;
        end
    endtask

    // Model advances on every clock edge and queues the expected outputs.
    always @(posedge clk) begin
        mon_done = 1'b0;
        if (!rst_n) model_reset();
        else        model_step(en, req);
        exp_q.push_back(make_rec(m_owner, m_idx, m_pre));
    end

    // Asynchronous reset replaces the not-yet-checked expectation.
    always @(negedge rst_n) begin
        model_reset();
        exp_q.delete();
        if (!mon_done) exp_q.push_back(make_rec(-1, 0, 1'b0));
    end

    // Monitor: compare the DUT outputs away from the active edge.
    always @(negedge clk) begin
        logic [REC_W-1:0] exp_v;
        logic [REC_W-1:0] act_v;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL queue_empty t=%0t: no expected entry for DUT output gnt=%h", $time, gnt);
        end else begin
            exp_v = exp_q.pop_front();
            act_v = {gnt, gnt_idx, gnt_valid, preempt};
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL outputs t=%0t: got gnt=%h idx=%0d valid=%b pre=%b, expected gnt=%h idx=%0d valid=%b pre=%b",
                         $time, act_v[21:6], act_v[5:2], act_v[1], act_v[0],
                         exp_v[21:6], exp_v[5:2], exp_v[1], exp_v[0]);
            end
        end
        mon_done = 1'b1;
    end

    // ---------------- driver tasks ----------------
    // Apply en/req just after an edge and hold them for 'cycles' edges.
    task automatic drive(input bit e, input logic [15:0] r, input int cycles);
        @(posedge clk);
        #1;
        en  = e;
        req = r;
        repeat (cycles - 1) @(posedge clk);
    endtask

    // Assert reset between edges, hold it over 'cycles' edges, release.
    task automatic pulse_reset(input int cycles);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        repeat (cycles) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] r;
        logic [15:0] mask;

        // Reset held with every requester asking, then released with en=1.
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        drive(1'b1, 16'hFFFF, 2);
        drive(1'b1, 16'h0000, 3);

        // Single grant to idx4, dropped after three cycles.
        drive(1'b1, 16'h0010, 3);
        drive(1'b1, 16'h0000, 4);

        // Two stuck requesters alternate on timeout.
        drive(1'b1, 16'h8001, 40);
        drive(1'b1, 16'h0000, 3);

        // Wrap-around: idx15 owns, then everyone asks.
        drive(1'b1, 16'h8000, 3);
        drive(1'b1, 16'hFFFF, 40);
        drive(1'b1, 16'h0000, 3);

        // en gating during a grant to idx3, then blocked, then idx4.
        drive(1'b1, 16'h0008, 3);
        drive(1'b0, 16'hFFFF, 6);
        drive(1'b1, 16'hFFFF, 4);
        drive(1'b1, 16'h0000, 3);

        // Asynchronous reset during a grant to idx9, then idx9 again.
        drive(1'b1, 16'h0200, 3);
        pulse_reset(2);
        drive(1'b1, 16'h0200, 4);
        drive(1'b1, 16'h0000, 3);

        // Randomized traffic with persistent, occasionally sparse requests.
        r    = 16'($urandom);
        mask = 16'hFFFF;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) begin
                if ($urandom_range(0, 2) == 0) mask = 16'hFFFF;
                else mask = 16'($urandom) & 16'($urandom) & 16'($urandom);
            end
            @(posedge clk);
            #1;
            for (int b = 0; b < 16; b++) begin
                if ($urandom_range(0, 11) == 0) r[b] = ~r[b];
            end
            en  = ($urandom_range(0, 19) != 0);
            req = r & mask;
            if ($urandom_range(0, 399) == 0) begin
                #1;
                rst_n = 1'b0;
                repeat (2) @(posedge clk);
                #2;
                rst_n = 1'b1;
            end
        end

        drive(1'b1, 16'h0000, 3);
        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
